// File: rtl/pila_parametrica.sv
// Parametrised LIFO stack: push/pop/replace/flush, occupancy and full/empty flags,
// sticky overflow/underflow, registered top-of-stack that reads 0 when empty.
module pila_parametrica #(
  parameter int DATA  = 8,
  parameter int DEPTH = 512,
  localparam int NW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic            vaciar,
  input  logic [DATA-1:0] entradaDatos,
  output logic [DATA-1:0] salidaDatos,
  output logic [NW-1:0]   nivel,
  output logic            vacia,
  output logic            llena,
  output logic            desbordamiento,
  output logic            subdesbordamiento
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA-1:0] r_mem [0:DEPTH-1];
  logic [NW-1:0]   r_nivel;
  logic [DATA-1:0] r_top;
  logic            r_ovf;
  logic            r_unf;

  logic            w_vacia;
  logic            w_llena;
  logic [NW-1:0]   w_nivel_nx;
  logic [DATA-1:0] w_top_nx;
  logic            w_ovf_nx;
  logic            w_unf_nx;
  logic            w_wr_req;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_addr;

  assign w_vacia = (r_nivel == '0);
  assign w_llena = (r_nivel == NW'(DEPTH));

  always_comb begin
    w_nivel_nx = r_nivel;
    w_top_nx   = r_top;
    w_ovf_nx   = r_ovf;
    w_unf_nx   = r_unf;
    w_wr_req   = 1'b0;
    w_wr_addr  = '0;
    unique case ({push, pop})
      2'b11: begin
        // Replace overwrites the current top; on an empty stack it degrades to a plain push.
        w_wr_req = 1'b1;
        w_top_nx = entradaDatos;
        if (w_vacia) begin
          w_wr_addr  = '0;
          w_nivel_nx = NW'(1);
        end else begin
          w_wr_addr  = AW'(r_nivel - NW'(1));
        end
      end
      2'b10: begin
        if (w_llena) begin
          w_ovf_nx = 1'b1;
        end else begin
          w_wr_req   = 1'b1;
          w_wr_addr  = AW'(r_nivel);
          w_nivel_nx = r_nivel + NW'(1);
          w_top_nx   = entradaDatos;
        end
      end
      2'b01: begin
        if (w_vacia) begin
          w_unf_nx = 1'b1;
        end else if (r_nivel == NW'(1)) begin
          w_nivel_nx = '0;
          w_top_nx   = '0;
        end else begin
          // The new top is read straight from the array so back-to-back pops need no bubble.
          w_nivel_nx = r_nivel - NW'(1);
          w_top_nx   = r_mem[AW'(r_nivel - NW'(2))];
        end
      end
      default: ;
    endcase
  end

  assign w_wr_en = w_wr_req && reset_n && !vaciar;

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_wr_addr] <= entradaDatos;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || vaciar) begin
      r_nivel <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_nivel <= w_nivel_nx;
      r_top   <= w_top_nx;
      r_ovf   <= w_ovf_nx;
      r_unf   <= w_unf_nx;
    end
  end

  assign salidaDatos       = r_top;
  assign nivel             = r_nivel;
  assign vacia             = w_vacia;
  assign llena             = w_llena;
  assign desbordamiento    = r_ovf;
  assign subdesbordamiento = r_unf;

endmodule

// File: tb/tb_pila_parametrica.sv
// Bench for pila_parametrica: vector table at 8x4, directed replace sequence at 8x2,
// random soak at 16x5 against a queue-based reference.
module tb_pila_parametrica;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- instance A: DATA=8, DEPTH=4 ----------------
  logic       a_rst = 1'b0, a_push = 1'b0, a_pop = 1'b0, a_vac = 1'b0;
  logic [7:0] a_din = '0, a_dout;
  logic [2:0] a_nivel;
  logic       a_vacia, a_llena, a_ovf, a_unf;

  pila_parametrica #(.DATA(8), .DEPTH(4)) u_a (
    .clk(clk), .reset_n(a_rst), .push(a_push), .pop(a_pop), .vaciar(a_vac),
    .entradaDatos(a_din), .salidaDatos(a_dout), .nivel(a_nivel), .vacia(a_vacia),
    .llena(a_llena), .desbordamiento(a_ovf), .subdesbordamiento(a_unf));

  // ---------------- instance B: DATA=8, DEPTH=2 ----------------
  logic       b_rst = 1'b0, b_push = 1'b0, b_pop = 1'b0, b_vac = 1'b0;
  logic [7:0] b_din = '0, b_dout;
  logic [1:0] b_nivel;
  logic       b_vacia, b_llena, b_ovf, b_unf;

  pila_parametrica #(.DATA(8), .DEPTH(2)) u_b (
    .clk(clk), .reset_n(b_rst), .push(b_push), .pop(b_pop), .vaciar(b_vac),
    .entradaDatos(b_din), .salidaDatos(b_dout), .nivel(b_nivel), .vacia(b_vacia),
    .llena(b_llena), .desbordamiento(b_ovf), .subdesbordamiento(b_unf));

  // ---------------- instance C: DATA=16, DEPTH=5 ----------------
  logic        c_rst = 1'b0, c_push = 1'b0, c_pop = 1'b0, c_vac = 1'b0;
  logic [15:0] c_din = '0, c_dout;
  logic [2:0]  c_nivel;
  logic        c_vacia, c_llena, c_ovf, c_unf;

  pila_parametrica #(.DATA(16), .DEPTH(5)) u_c (
    .clk(clk), .reset_n(c_rst), .push(c_push), .pop(c_pop), .vaciar(c_vac),
    .entradaDatos(c_din), .salidaDatos(c_dout), .nivel(c_nivel), .vacia(c_vacia),
    .llena(c_llena), .desbordamiento(c_ovf), .subdesbordamiento(c_unf));

  typedef struct {
    logic       rst_n, psh, pp, vac;
    logic [7:0] din;
    logic [7:0] dout;
    int         niv;
    logic       ovf, unf;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic rst_n, psh, pp, vac, input logic [7:0] din,
                     input logic [7:0] dout, input int niv, input logic ovf, unf);
    vec_t v;
    v.rst_n = rst_n; v.psh = psh; v.pp = pp; v.vac = vac; v.din = din;
    v.dout = dout; v.niv = niv; v.ovf = ovf; v.unf = unf;
    tab.push_back(v);
  endtask

  task automatic b_op(input logic ps, input logic pp, input logic [7:0] d);
    b_push = ps; b_pop = pp; b_din = d;
    @(posedge clk); #1;
  endtask

  task automatic b_chk(input string nm, input logic [7:0] dout, input int niv,
                       input logic ovf, input logic unf);
    chk({nm, "_dout"}, 32'(b_dout), 32'(dout));
    chk({nm, "_nivel"}, 32'(b_nivel), niv);
    chk({nm, "_ovf"}, 32'(b_ovf), 32'(ovf));
    chk({nm, "_unf"}, 32'(b_unf), 32'(unf));
  endtask

  logic [15:0] q[$];
  logic        m_ovf, m_unf;
  logic [15:0] m_top;

  initial begin
    //   rst psh pop vac din    dout  niv ovf unf
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0);
    add(1, 1, 0, 0, 8'h22, 8'h22, 2, 0, 0);
    add(1, 1, 0, 0, 8'h33, 8'h33, 3, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h22, 2, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h11, 1, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, 1, 0, 0, 8'h01, 8'h01, 1, 0, 0);
    add(1, 1, 0, 0, 8'h02, 8'h02, 2, 0, 0);
    add(1, 1, 0, 0, 8'h03, 8'h03, 3, 0, 0);
    add(1, 1, 0, 1, 8'h04, 8'h00, 0, 0, 0);
    add(1, 1, 0, 0, 8'hA0, 8'hA0, 1, 0, 0);
    add(1, 1, 0, 0, 8'hA1, 8'hA1, 2, 0, 0);
    add(1, 1, 0, 0, 8'hA2, 8'hA2, 3, 0, 0);
    add(1, 1, 0, 0, 8'hA3, 8'hA3, 4, 0, 0);
    add(1, 1, 0, 0, 8'hFF, 8'hA3, 4, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'hA3, 4, 1, 0);
    add(1, 0, 1, 0, 8'h00, 8'hA2, 3, 1, 0);
    add(1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);
    add(1, 1, 0, 0, 8'h5A, 8'h5A, 1, 0, 1);
    add(1, 0, 0, 0, 8'h00, 8'h5A, 1, 0, 1);
    add(1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    add(1, 1, 0, 0, 8'h44, 8'h44, 1, 0, 0);
    add(0, 1, 0, 0, 8'h55, 8'h00, 0, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);

    #2;
    for (int i = 0; i < tab.size(); i++) begin
      a_rst = tab[i].rst_n; a_push = tab[i].psh; a_pop = tab[i].pp;
      a_vac = tab[i].vac;   a_din  = tab[i].din;
      @(posedge clk); #1;
      chk($sformatf("A%0d_dout", i),  32'(a_dout),  32'(tab[i].dout));
      chk($sformatf("A%0d_nivel", i), 32'(a_nivel), tab[i].niv);
      chk($sformatf("A%0d_vacia", i), 32'(a_vacia), 32'(tab[i].niv == 0));
      chk($sformatf("A%0d_llena", i), 32'(a_llena), 32'(tab[i].niv == 4));
      chk($sformatf("A%0d_ovf", i),   32'(a_ovf),   32'(tab[i].ovf));
      chk($sformatf("A%0d_unf", i),   32'(a_unf),   32'(tab[i].unf));
    end

    // Replace at DEPTH=2
    @(posedge clk); #1;
    b_rst = 1'b1;
    b_op(1, 0, 8'h01);
    b_op(1, 0, 8'h02);
    b_chk("B_full", 8'h02, 2, 0, 0);
    chk("B_llena", 32'(b_llena), 32'd1);
    b_op(1, 1, 8'h77);
    b_chk("B_repl_full", 8'h77, 2, 0, 0);
    b_op(0, 1, 8'h00);
    b_chk("B_pop_after_repl", 8'h01, 1, 0, 0);
    b_op(0, 1, 8'h00);
    b_chk("B_pop_to_empty", 8'h00, 0, 0, 0);
    b_op(1, 1, 8'h33);
    b_chk("B_repl_empty", 8'h33, 1, 0, 0);
    b_op(1, 0, 8'h44);
    b_op(0, 1, 8'h00);
    b_chk("B_push_then_pop", 8'h33, 1, 0, 0);

    // Randomised soak at DATA=16, DEPTH=5
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    c_rst = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 10000; n++) begin
      c_rst  = ($urandom_range(0, 511) != 0);
      c_vac  = ($urandom_range(0, 63) == 0);
      c_push = $urandom_range(0, 1) != 0;
      c_pop  = $urandom_range(0, 1) != 0;
      c_din  = 16'($urandom);
      @(posedge clk);
      if (!c_rst || c_vac) begin
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else if (c_push && c_pop) begin
        if (q.size() == 0) q.push_back(c_din);
        else q[q.size()-1] = c_din;
      end else if (c_push) begin
        if (q.size() == 5) m_ovf = 1'b1;
        else q.push_back(c_din);
      end else if (c_pop) begin
        if (q.size() == 0) m_unf = 1'b1;
        else void'(q.pop_back());
      end
      m_top = (q.size() == 0) ? 16'h0000 : q[q.size()-1];
      #1;
      chk($sformatf("C%0d_dout", n),  32'(c_dout),  32'(m_top));
      chk($sformatf("C%0d_nivel", n), 32'(c_nivel), q.size());
      chk($sformatf("C%0d_ovf", n),   32'(c_ovf),   32'(m_ovf));
      chk($sformatf("C%0d_unf", n),   32'(c_unf),   32'(m_unf));
      if (n % 16 == 0) begin
        chk($sformatf("C%0d_vacia", n), 32'(c_vacia), 32'(q.size() == 0));
        chk($sformatf("C%0d_llena", n), 32'(c_llena), 32'(q.size() == 5));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
